// File: rtl/fetch_control_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_types
// Shared LC-3b datapath types used by the fetch-stage control.
//   lc3b_pcmux_sel     : 3-bit select for the 8:1 PC mux
//   PCMUX_*            : PC mux source encodings
//   pcmux_redirect_src : maps a redirect source onto a PC mux select;
//                        unknown sources fall back to PC+2
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef logic [2:0] lc3b_pcmux_sel;

  localparam lc3b_pcmux_sel PCMUX_PLUS2  = 3'd0;
  localparam lc3b_pcmux_sel PCMUX_BRANCH = 3'd1;
  localparam lc3b_pcmux_sel PCMUX_SR1    = 3'd2;
  localparam lc3b_pcmux_sel PCMUX_MDR    = 3'd3;
  localparam lc3b_pcmux_sel PCMUX_BRADD  = 3'd4;

  function automatic lc3b_pcmux_sel pcmux_redirect_src(input lc3b_pcmux_sel sel);
    lc3b_pcmux_sel w_sel;
    w_sel = PCMUX_PLUS2;
    if ((sel >= PCMUX_BRANCH) && (sel <= PCMUX_BRADD)) begin
      w_sel = sel;
    end
    return w_sel;
  endfunction

endpackage

// File: rtl/fetch_control_watchdog.sv
// ---------------------------------------------------------------------------
// fetch_watchdog
// Counts cycles spent waiting on instruction memory and raises a sticky
// timeout flag once the wait reaches MEM_TIMEOUT cycles.
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   count_en    in   one more waiting cycle
//   clear       in   restart the wait count (response seen / not fetching)
//   mem_timeout out  sticky error flag, cleared only by reset
// ---------------------------------------------------------------------------
module fetch_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clear,
  output logic mem_timeout
);

  localparam logic [7:0] TC = 8'(MEM_TIMEOUT);

  logic [7:0] r_cnt;
  logic       r_timeout;
  logic [7:0] w_cnt_next;

  // Saturates at 255 so a very long stall can never wrap back below TC.
  assign w_cnt_next = (r_cnt == 8'hFF) ? r_cnt : (r_cnt + 8'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (clear) begin
        r_cnt <= '0;
      end else if (count_en) begin
        r_cnt <= w_cnt_next;
        if (w_cnt_next >= TC) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign mem_timeout = r_timeout;

endmodule

// File: rtl/fetch_control.sv
// ---------------------------------------------------------------------------
// fetch_control
// Sequences the LC-3b fetch stage: issues instruction reads from the current
// PC, loads the IR on response, and advances or redirects the PC.
//
//   state | meaning
//   IDLE  | one quiet cycle after reset, no read issued
//   FETCH | read outstanding at the current PC
//   HOLD  | IR valid, decode stalled, waiting for consume or redirect
//
// Ports:
//   clk            in   system clock
//   rst_n          in   synchronous active-low reset
//   imem_resp      in   instruction memory data valid this cycle
//   stall          in   decode cannot accept an instruction
//   redirect_valid in   redirect request, held until redirect_ack
//   redirect_sel   in   PC mux source for the redirect
//   imem_read      out  read request at current PC
//   load_pc        out  PC register load enable
//   pcmux_sel      out  PC mux select (PC+2 when not loading)
//   load_ir        out  capture memory data into IR
//   if_valid       out  IR holds a valid unconsumed instruction
//   redirect_ack   out  redirect applied this cycle
//   mem_timeout    out  sticky memory timeout flag
// ---------------------------------------------------------------------------
module fetch_control
  import lc3b_types::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          imem_resp,
  input  logic          stall,
  input  logic          redirect_valid,
  input  lc3b_pcmux_sel redirect_sel,
  output logic          imem_read,
  output logic          load_pc,
  output lc3b_pcmux_sel pcmux_sel,
  output logic          load_ir,
  output logic          if_valid,
  output logic          redirect_ack,
  output logic          mem_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic         r_if_valid;
  logic         w_if_valid_next;
  logic         w_wd_count_en;
  logic         w_wd_clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_if_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_if_valid <= w_if_valid_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_if_valid_next = r_if_valid;
    imem_read       = 1'b0;
    load_pc         = 1'b0;
    pcmux_sel       = PCMUX_PLUS2;
    load_ir         = 1'b0;
    redirect_ack    = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_state_next = FETCH;
      end

      FETCH: begin
        imem_read = 1'b1;
        if (imem_resp) begin
          if (redirect_valid) begin
            // Fetched instruction is on the wrong path; drop it.
            load_pc         = 1'b1;
            pcmux_sel       = pcmux_redirect_src(redirect_sel);
            redirect_ack    = 1'b1;
            w_if_valid_next = 1'b0;
          end else if (!stall) begin
            load_ir         = 1'b1;
            load_pc         = 1'b1;
            w_if_valid_next = 1'b1;
          end else begin
            load_ir         = 1'b1;
            w_if_valid_next = 1'b1;
            w_state_next    = HOLD;
          end
        end else if (!stall) begin
          // A redirect without a response waits: PC is frozen while a read
          // is outstanding.
          w_if_valid_next = 1'b0;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          load_pc         = 1'b1;
          pcmux_sel       = pcmux_redirect_src(redirect_sel);
          redirect_ack    = 1'b1;
          w_if_valid_next = 1'b0;
          w_state_next    = FETCH;
        end else if (!stall) begin
          load_pc         = 1'b1;
          w_if_valid_next = 1'b0;
          w_state_next    = FETCH;
        end
      end

      default: begin
        w_state_next    = IDLE;
        w_if_valid_next = 1'b0;
      end
    endcase
  end

  assign w_wd_count_en = (r_state == FETCH) && !imem_resp;
  assign w_wd_clear    = (r_state != FETCH) || imem_resp;

  fetch_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .count_en    (w_wd_count_en),
    .clear       (w_wd_clear),
    .mem_timeout (mem_timeout)
  );

  assign if_valid = r_if_valid;

endmodule

// File: tb/tb_fetch_control.sv
// ---------------------------------------------------------------------------
// tb_fetch_control
// Cycle-by-cycle scoreboard bench for fetch_control. Each stimulus vector is
// {rst_n, imem_resp, stall, redirect_valid, redirect_sel[2:0]}; each expected
// vector is {imem_read, load_pc, pcmux_sel[2:0], load_ir, if_valid,
// redirect_ack, mem_timeout}, sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_control;
  import lc3b_types::*;

  logic          clk;
  logic          rst_n;
  logic          imem_resp;
  logic          stall;
  logic          redirect_valid;
  lc3b_pcmux_sel redirect_sel;
  logic          imem_read;
  logic          load_pc;
  lc3b_pcmux_sel pcmux_sel;
  logic          load_ir;
  logic          if_valid;
  logic          redirect_ack;
  logic          mem_timeout;

  logic [8:0]    w_obs;
  logic [8:0]    sb_q[$];
  int            n_checks;
  int            n_fail;

  fetch_control #(
    .MEM_TIMEOUT (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_resp      (imem_resp),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_sel   (redirect_sel),
    .imem_read      (imem_read),
    .load_pc        (load_pc),
    .pcmux_sel      (pcmux_sel),
    .load_ir        (load_ir),
    .if_valid       (if_valid),
    .redirect_ack   (redirect_ack),
    .mem_timeout    (mem_timeout)
  );

  assign w_obs = {imem_read, load_pc, pcmux_sel, load_ir, if_valid, redirect_ack, mem_timeout};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus is only ever legal redirect sources.
  always @(negedge clk) begin
    if (redirect_valid) begin
      assert ((redirect_sel >= PCMUX_BRANCH) && (redirect_sel <= PCMUX_BRADD));
    end
  end

  task automatic drive(input logic [6:0] s);
    @(posedge clk);
    #1;
    {rst_n, imem_resp, stall, redirect_valid, redirect_sel} = s;
  endtask

  task automatic test_reset();
    logic [6:0] stim [3];
    logic [8:0] expv [3];
    logic [8:0] e;
    stim = '{7'b0_0_0_0_000, 7'b0_0_0_0_000, 7'b1_0_0_0_000};
    expv = '{9'b000000000, 9'b000000000, 9'b000000000};
    for (int i = 0; i < 3; i++) begin
      drive(stim[i]);
      sb_q.push_back(expv[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %b expected %b", i, w_obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] stim [4];
    logic [8:0] expv [4];
    logic [8:0] e;
    stim = '{7'b1_1_0_0_000, 7'b1_1_0_0_000, 7'b1_1_0_0_000, 7'b1_1_0_0_000};
    expv = '{9'b110001000, 9'b110001100, 9'b110001100, 9'b110001100};
    for (int i = 0; i < 4; i++) begin
      drive(stim[i]);
      sb_q.push_back(expv[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", i, w_obs, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [6:0] stim [7];
    logic [8:0] expv [7];
    logic [8:0] e;
    stim = '{7'b1_1_1_0_000, 7'b1_0_1_0_000, 7'b1_0_1_0_000, 7'b1_0_1_0_000,
             7'b1_0_0_0_000, 7'b1_0_0_0_000, 7'b1_1_0_0_000};
    expv = '{9'b100001100, 9'b000000100, 9'b000000100, 9'b000000100,
             9'b010000100, 9'b100000000, 9'b110001000};
    for (int i = 0; i < 7; i++) begin
      drive(stim[i]);
      sb_q.push_back(expv[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL stall[%0d]: got %b expected %b", i, w_obs, e);
      end
    end
  endtask

  task automatic test_redirect_latency();
    logic [6:0] stim [4];
    logic [8:0] expv [4];
    logic [8:0] e;
    stim = '{7'b1_0_0_1_100, 7'b1_0_0_1_100, 7'b1_1_0_1_100, 7'b1_1_1_0_000};
    expv = '{9'b100000100, 9'b100000000, 9'b111000010, 9'b100001000};
    for (int i = 0; i < 4; i++) begin
      drive(stim[i]);
      sb_q.push_back(expv[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL redirect_latency[%0d]: got %b expected %b", i, w_obs, e);
      end
    end
  endtask

  task automatic test_hold_redirect();
    logic [6:0] stim [2];
    logic [8:0] expv [2];
    logic [8:0] e;
    stim = '{7'b1_0_1_1_010, 7'b1_1_0_0_000};
    expv = '{9'b010100110, 9'b110001000};
    for (int i = 0; i < 2; i++) begin
      drive(stim[i]);
      sb_q.push_back(expv[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL hold_redirect[%0d]: got %b expected %b", i, w_obs, e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] s;
    logic [8:0] e;
    for (int i = 0; i < 12; i++) begin
      s = (i < 10) ? 7'b1_0_0_0_000 : 7'b1_1_0_0_000;
      drive(s);
      if (i == 0)       sb_q.push_back(9'b100000100);
      else if (i < 4)   sb_q.push_back(9'b100000000);
      else if (i < 10)  sb_q.push_back(9'b100000001);
      else if (i == 10) sb_q.push_back(9'b110001001);
      else              sb_q.push_back(9'b110001101);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL timeout[%0d]: got %b expected %b", i, w_obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [6:0] stim [4];
    logic [8:0] expv [4];
    logic [8:0] e;
    stim = '{7'b0_0_0_0_000, 7'b1_1_0_0_000, 7'b1_1_0_0_000, 7'b1_1_0_0_000};
    expv = '{9'b100000101, 9'b000000000, 9'b110001000, 9'b110001100};
    for (int i = 0; i < 4; i++) begin
      drive(stim[i]);
      sb_q.push_back(expv[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_fetch[%0d]: got %b expected %b", i, w_obs, e);
      end
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    imem_resp      = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_sel   = PCMUX_PLUS2;

    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect_latency();
    test_hold_redirect();
    test_timeout();
    test_reset_mid_fetch();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_control.md
Name: fetch_control

Overview:
- Sequencing controller for the LC-3b instruction fetch stage (PC register, PC+2 incrementer, 8:1 PC mux, branch mux).
- Issues instruction-memory reads from the current PC and loads the IR on response.
- Advances the PC, or redirects it for branches, JMP/JSR and TRAP, through a valid/ack handshake. Honours decode-stage stalls.
- Sits between the fetch datapath, instruction memory and the pipeline hazard/branch-resolution logic.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent in FETCH without imem_resp before mem_timeout is flagged. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- imem_resp  input  1  instruction memory response; data valid this cycle.
- stall  input  1  decode cannot accept a new instruction this cycle.
- redirect_valid  input  1  redirect request. Held high with redirect_sel stable until redirect_ack.
- redirect_sel  input  3  PC mux source for the redirect: 1 branch mux, 2 SR1, 3 mem_rdata (trap vector), 4 br_add.
- imem_read  output  1  instruction read request; address is the current PC.
- load_pc  output  1  PC register load enable.
- pcmux_sel  output  3  PC mux select; 0 = PC+2.
- load_ir  output  1  capture instruction memory data into the IR.
- if_valid  output  1  registered: IR holds a valid, unconsumed instruction.
- redirect_ack  output  1  one-cycle pulse: redirect applied this cycle.
- mem_timeout  output  1  sticky error flag.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, if_valid=0, mem_timeout=0, timeout counter=0. All combinational outputs are 0 while in IDLE.
- Reset mid-transaction abandons the fetch. The memory model must tolerate read deassertion.
- Combinational outputs are Mealy, from state and inputs.
- pcmux_sel=0 whenever load_pc=0.
- redirect_ack=1 exactly when load_pc=1 with a redirect source.
- IDLE: imem_read=0. Next state is always FETCH, so the first read is issued in the 2nd cycle after rst_n rises. A redirect in IDLE is not acked.
- FETCH: imem_read=1.
  - imem_resp=0: stay in FETCH. Counter increments, saturating at 255.
  - imem_resp=1 and redirect_valid=1 (highest priority; stall ignored): instruction discarded, load_ir=0. load_pc=1, pcmux_sel=redirect_sel, redirect_ack=1, if_valid<=0. Stay in FETCH; the new address is requested next cycle.
  - imem_resp=1, no redirect, stall=0: load_ir=1, load_pc=1, pcmux_sel=0, if_valid<=1. Stay in FETCH (back-to-back fetch).
  - imem_resp=1, no redirect, stall=1: load_ir=1, load_pc=0, if_valid<=1. Go to HOLD.
  - redirect_valid=1 without imem_resp: no ack. The PC must not change during an outstanding read. The request waits for the response.
  - Counter clears on every imem_resp and on leaving FETCH.
  - Counter reaching MEM_TIMEOUT with imem_resp=0 sets mem_timeout=1 until reset. Fetch continues to wait.
- HOLD: imem_read=0, load_ir=0.
  - redirect_valid=1: load_pc=1, pcmux_sel=redirect_sel, ack, if_valid<=0, go to FETCH. Takes priority over stall.
  - Else stall=0: decode consumes the IR. load_pc=1, pcmux_sel=0, if_valid<=0, go to FETCH.
  - Else stay in HOLD; IR and PC hold.
- if_valid in FETCH with imem_resp=0: cleared if stall=0 (consumed), held if stall=1.
- Illegal redirect_sel (0, 5, 6, 7): the redirect is still acked, but pcmux_sel=0 (PC+2) is driven. The bench asserts this never occurs.
- Cycles per instruction with 1-cycle memory and no stalls: 1.

Decomposition:
- Package lc3b_types gains:
  - typedef lc3b_pcmux_sel (logic [2:0]).
  - Constants PCMUX_PLUS2=0, PCMUX_BRANCH=1, PCMUX_SR1=2, PCMUX_MDR=3, PCMUX_BRADD=4.
- The fetch_state enum (IDLE, FETCH, HOLD) stays local to the module.
- One sub-module: fetch_watchdog. It contains the 8-bit saturating counter and the sticky mem_timeout, with inputs clk, rst_n, count_en, clear and a MEM_TIMEOUT parameter.

Test Plan:
- Reset then 1-cycle memory, stall=0 -> imem_read rises 2nd cycle after rst_n=1. load_pc/load_ir pulse every cycle with pcmux_sel=0; if_valid=1 from the first response.
- Stall held 3 cycles at a response -> load_ir once, state HOLD, imem_read=0, if_valid=1 for 3 cycles. On stall=0: load_pc=1, pcmux_sel=0, FETCH.
- redirect_valid=1, sel=4 raised in FETCH with a 3-cycle memory latency -> no ack for 2 cycles. At the imem_resp cycle: load_ir=0, load_pc=1, pcmux_sel=4, redirect_ack=1, if_valid=0.
- redirect sel=2 plus stall=1 in HOLD -> ack in the same cycle, pcmux_sel=2, FETCH next; stall ignored.
- MEM_TIMEOUT=4, imem_resp withheld 10 cycles -> mem_timeout rises after the 4th waiting cycle, stays 1 after the response, clears only on rst_n=0.
- rst_n=0 mid-FETCH for 1 cycle -> all outputs 0 next cycle, if_valid=0, state IDLE; fetch resumes 2 cycles after release.
